// File: rtl/chnl_rx.sv
// Riffa CHNL receiver: accepts a host transaction, buffers PCIe beats in a FIFO and repacks
// them into an RX_WIDTH valid/ready stream. Define CHNL_RX_STATS_EN to add statistics outputs.
module chnl_rx #(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int RX_WIDTH         = 32,
  parameter int GCD              = 32,
  parameter int FIFO_DEPTH       = 512
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        o_val,
  input  logic                        o_rdy,
  output logic [RX_WIDTH-1:0]         o_data,
  output logic                        CHNL_RX_CLK,
  input  logic                        CHNL_RX,
  output logic                        CHNL_RX_ACK,
  input  logic                        CHNL_RX_LAST,
  input  logic [31:0]                 CHNL_RX_LEN,
  input  logic [30:0]                 CHNL_RX_OFF,
  input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
  input  logic                        CHNL_RX_DATA_VALID,
  output logic                        CHNL_RX_DATA_REN
`ifdef CHNL_RX_STATS_EN
  ,
  output logic [31:0]                 o_stat_txns,
  output logic [31:0]                 o_stat_beats,
  output logic [31:0]                 o_stat_drop
`endif
);

  localparam int WPB   = C_PCI_DATA_WIDTH / 32;
  localparam int LOG2W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int NI    = C_PCI_DATA_WIDTH / GCD;
  localparam int NO    = RX_WIDTH / GCD;
  localparam int BUFW  = (NI + NO) * GCD;
  localparam int CW    = $clog2(NI + NO + 1);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] NI_C     = CW'(NI);
  localparam logic [CW-1:0] NO_C     = CW'(NO);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK  = 2'd1;
  localparam logic [1:0] S_RECV = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_beats_left;
  logic [31:0] w_beats;
  logic        w_xfer, w_push, w_trunc, w_in_rdy;
  logic        w_unused_ok;

  assign CHNL_RX_CLK = clk;
  assign w_unused_ok = ^{CHNL_RX_LAST, CHNL_RX_OFF};

  generate
    if (WPB == 1) begin : g_beats_w1
      assign w_beats = CHNL_RX_LEN;
    end else begin : g_beats_wn
      // Round up to whole beats without forming LEN + WPB - 1 (no 32-bit overflow).
      assign w_beats = (CHNL_RX_LEN >> LOG2W) + {31'd0, |CHNL_RX_LEN[LOG2W-1:0]};
    end
  endgenerate

  always_comb begin
    CHNL_RX_ACK      = (r_state == S_ACK);
    CHNL_RX_DATA_REN = (r_state == S_RECV) ? w_in_rdy : (r_state == S_DONE);
    w_xfer           = CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN;
    w_push           = w_xfer && (r_state == S_RECV);
    w_trunc          = (r_state == S_RECV) && !CHNL_RX && !(w_xfer && r_beats_left == 32'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_beats_left <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (CHNL_RX) begin
          r_beats_left <= w_beats;
          r_state      <= S_ACK;
        end
        S_ACK: r_state <= (r_beats_left != 32'd0) ? S_RECV : S_DONE;
        S_RECV: begin
          if (w_xfer) r_beats_left <= r_beats_left - 32'd1;
          if (w_xfer && r_beats_left == 32'd1) r_state <= S_DONE;
          else if (w_trunc)                    r_state <= S_IDLE;
        end
        default: if (!CHNL_RX) r_state <= S_IDLE;
      endcase
    end
  end

  // Beat FIFO: block-RAM array with a registered read stage feeding the repacker.
  logic [C_PCI_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [C_PCI_DATA_WIDTH-1:0] r_fo_data;
  logic [AW-1:0]               r_wr_ptr, r_rd_ptr;
  logic [AW:0]                 r_fifo_cnt;
  logic                        r_fo_val;
  logic                        w_mem_pop, w_fo_load;

  assign w_in_rdy  = (r_fifo_cnt != FULL_CNT);
  assign w_mem_pop = (r_fifo_cnt != '0) && (!r_fo_val || w_fo_load);

  always_ff @(posedge clk) begin
    if (w_push)    r_mem[r_wr_ptr] <= CHNL_RX_DATA;
    if (w_mem_pop) r_fo_data       <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_fo_val   <= 1'b0;
    end else begin
      if (w_push)    r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_mem_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_mem_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + (AW+1)'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - (AW+1)'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      if (w_mem_pop)      r_fo_val <= 1'b1;
      else if (w_fo_load) r_fo_val <= 1'b0;
    end
  end

  // Repacker: granule shift buffer, LS granule out first; upper unused bits stay zero.
  logic [BUFW-1:0] r_buf, w_buf_shift, w_buf_ins;
  logic [CW-1:0]   r_rp_cnt, w_cnt_ap;
  logic            w_rp_pop;

  always_comb begin
    w_rp_pop    = (r_rp_cnt >= NO_C) && o_rdy;
    w_cnt_ap    = w_rp_pop ? (r_rp_cnt - NO_C) : r_rp_cnt;
    w_fo_load   = r_fo_val && (w_cnt_ap <= NO_C);
    w_buf_shift = w_rp_pop ? (r_buf >> RX_WIDTH) : r_buf;
    w_buf_ins   = w_fo_load ? (BUFW'(r_fo_data) << (int'(w_cnt_ap) * GCD)) : '0;
    o_val       = (r_rp_cnt >= NO_C);
    o_data      = r_buf[RX_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf    <= '0;
      r_rp_cnt <= '0;
    end else begin
      r_buf    <= w_buf_shift | w_buf_ins;
      r_rp_cnt <= w_cnt_ap + (w_fo_load ? NI_C : CW'(0));
    end
  end

`ifdef CHNL_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stat_txns  <= 32'd0;
      o_stat_beats <= 32'd0;
      o_stat_drop  <= 32'd0;
    end else begin
      if (CHNL_RX_ACK && o_stat_txns != '1) o_stat_txns  <= o_stat_txns + 32'd1;
      if (w_push && o_stat_beats != '1)     o_stat_beats <= o_stat_beats + 32'd1;
      if (((w_xfer && r_state == S_DONE) || w_trunc) && o_stat_drop != '1)
        o_stat_drop <= o_stat_drop + 32'd1;
    end
  end
`endif

endmodule
